id_ex_hazard: RTL and testbench

ID_EX_HAZARD -- requirements
Module: id_ex_hazard

---
 rtl/id_ex_hazard.sv | 211 +++++++++++++++++++++
 tb/tb_id_ex_hazard.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard.sv
// -----------------------------------------------------------------------------
// id_ex_hazard
//   ID/EX pipeline register with load-use hazard detection for a classic
//   5-stage MIPS-style pipeline.
//
//   A load sitting in EX whose destination (ex_rt) is read by the instruction
//   in ID causes a one-cycle stall. The stall holds PC and IF/ID, and a bubble
//   is loaded into EX. A taken branch (flush) overrides the hazard. The stall
//   cycles are counted in a saturating counter that can be cleared.
//
// Parameters
//   W      datapath word width
//   CNT_W  stall-counter width
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   valid_in             ID holds a real instruction
//   flush                branch taken: kill the ID instruction
//   clr_cnt              synchronous clear of stall_cnt (beats increment)
//   RegDst..RegWrite     1-bit decode controls
//   ALUOp[2:0]           ALU operation class
//   rd1, rd2, imm, pc4   operands, sign-extended immediate, PC+4 (W bits)
//   rs, rt, rd           register specifiers
//   ex_*                 registered EX-stage copies of the above, plus ex_valid
//   stall                combinational: hold PC and IF/ID this cycle
//   stall_cnt            number of stall cycles seen (saturating)
// -----------------------------------------------------------------------------
module id_ex_hazard #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             valid_in,
  input  logic             flush,
  input  logic             clr_cnt,

  input  logic             RegDst,
  input  logic             Branch,
  input  logic             MemRead,
  input  logic             MemToReg,
  input  logic             MemWrite,
  input  logic             ALUSrc,
  input  logic             RegWrite,
  input  logic [2:0]       ALUOp,

  input  logic [W-1:0]     rd1,
  input  logic [W-1:0]     rd2,
  input  logic [W-1:0]     imm,
  input  logic [W-1:0]     pc4,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,

  output logic             ex_RegDst,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_MemToReg,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic             ex_RegWrite,
  output logic [2:0]       ex_ALUOp,
  output logic [W-1:0]     ex_rd1,
  output logic [W-1:0]     ex_rd2,
  output logic [W-1:0]     ex_imm,
  output logic [W-1:0]     ex_pc4,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic             ex_valid,

  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazState_t;

  hazState_t state;
  hazState_t nextState;

  logic usesRt;
  logic rsMatch;
  logic rtMatch;
  logic hazard;
  logic bubble;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // rt is a source operand for R-type ops (no immediate) and for stores
  // (store data comes from rt).
  assign usesRt  = ~ALUSrc | MemWrite;
  assign rsMatch = (ex_rt == rs);
  assign rtMatch = usesRt & (ex_rt == rt);

  // $0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign hazard  = ex_valid & ex_MemRead & (ex_rt != 5'd0) & valid_in
                 & (rsMatch | rtMatch);

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = RUN;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        // flush wins over the hazard: the dependent instruction is dead anyway
        stall     = hazard & ~flush & rst_n;
        nextState = stall ? STALL : RUN;
      end
      STALL: begin
        // EX now holds a bubble; the load has moved to MEM and forwarding
        // covers the re-presented instruction, so one cycle always suffices.
        stall     = 1'b0;
        nextState = RUN;
      end
      default: begin
        stall     = 1'b0;
        nextState = RUN;
      end
    endcase
  end

  // A bubble clears every control bit and ex_valid; data and specifier fields
  // still load from ID so they are observable but inert.
  assign bubble = stall | flush | ~valid_in;

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_RegDst   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUOp    <= '0;
      ex_valid    <= 1'b0;
    end else if (bubble) begin
      ex_RegDst   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUOp    <= '0;
      ex_valid    <= 1'b0;
    end else begin
      ex_RegDst   <= RegDst;
      ex_Branch   <= Branch;
      ex_MemRead  <= MemRead;
      ex_MemToReg <= MemToReg;
      ex_MemWrite <= MemWrite;
      ex_ALUSrc   <= ALUSrc;
      ex_RegWrite <= RegWrite;
      ex_ALUOp    <= ALUOp;
      ex_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      ex_imm <= '0;
      ex_pc4 <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
    end else begin
      ex_rd1 <= rd1;
      ex_rd2 <= rd2;
      ex_imm <= imm;
      ex_pc4 <= pc4;
      ex_rs  <= rs;
      ex_rt  <= rt;
      ex_rd  <= rd;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard
//   Directed bench for id_ex_hazard. The DUT is built with a 2-bit stall
//   counter so saturation is reachable in a few stall events. Inputs change
//   1 ns after the rising edge; registered outputs are sampled there too and
//   the combinational stall is sampled a further 1 ns after the inputs move.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             valid_in;
  logic             flush;
  logic             clr_cnt;
  logic             RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite;
  logic [2:0]       ALUOp;
  logic [W-1:0]     rd1, rd2, imm, pc4;
  logic [4:0]       rs, rt, rd;

  logic             ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg;
  logic             ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [2:0]       ex_ALUOp;
  logic [W-1:0]     ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [4:0]       ex_rs, ex_rt, ex_rd;
  logic             ex_valid;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  id_ex_hazard #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .flush       (flush),
    .clr_cnt     (clr_cnt),
    .RegDst      (RegDst),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemToReg    (MemToReg),
    .MemWrite    (MemWrite),
    .ALUSrc      (ALUSrc),
    .RegWrite    (RegWrite),
    .ALUOp       (ALUOp),
    .rd1         (rd1),
    .rd2         (rd2),
    .imm         (imm),
    .pc4         (pc4),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .ex_RegDst   (ex_RegDst),
    .ex_Branch   (ex_Branch),
    .ex_MemRead  (ex_MemRead),
    .ex_MemToReg (ex_MemToReg),
    .ex_MemWrite (ex_MemWrite),
    .ex_ALUSrc   (ex_ALUSrc),
    .ex_RegWrite (ex_RegWrite),
    .ex_ALUOp    (ex_ALUOp),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_pc4      (ex_pc4),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_valid    (ex_valid),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clearIn();
    valid_in = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    RegDst = 1'b0; Branch = 1'b0; MemRead = 1'b0; MemToReg = 1'b0;
    MemWrite = 1'b0; ALUSrc = 1'b0; RegWrite = 1'b0; ALUOp = 3'b000;
    rd1 = '0; rd2 = '0; imm = '0; pc4 = '0;
    rs = '0; rt = '0; rd = '0;
  endtask

  task automatic drvR(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    clearIn();
    valid_in = 1'b1; RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 3'b010;
    rs = s; rt = t; rd = d; rd1 = a; rd2 = b; pc4 = 32'h0000_0104;
  endtask

  task automatic drvLoad(input logic [4:0] s, input logic [4:0] t, input logic [W-1:0] off);
    clearIn();
    valid_in = 1'b1; MemRead = 1'b1; MemToReg = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1;
    rs = s; rt = t; imm = off;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load-use stall event: load $8 into EX, then an R-type reading $8.
  // Leaves the FSM back in RUN on return.
  task automatic stallEvent(input string tag, input logic doClr, input logic [CNT_W-1:0] expCnt);
    drvLoad(5'd1, 5'd8, 32'h0);
    tick();
    drvR(5'd8, 5'd3, 5'd4, 32'h11, 32'h22);
    clr_cnt = doClr;
    #1 check({tag, "_stall"}, stall, 1'b1);
    tick();
    check({tag, "_cnt"}, stall_cnt, expCnt);
    clearIn();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clearIn();
    rst_n = 1'b0;

    // reset state, before any clock edge
    #3;
    check("rst_valid", ex_valid, 1'b0);
    check("rst_regwr", ex_RegWrite, 1'b0);
    check("rst_rd1",   ex_rd1, 32'h0);
    check("rst_cnt",   stall_cnt, 2'd0);
    check("rst_stall", stall, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // R-type pass-through
    drvR(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    #1 check("pt_stall", stall, 1'b0);
    tick();
    check("pt_regdst", ex_RegDst, 1'b1);
    check("pt_rd1",    ex_rd1, 32'd5);
    check("pt_rd2",    ex_rd2, 32'd7);
    check("pt_aluop",  ex_ALUOp, 3'b010);
    check("pt_pc4",    ex_pc4, 32'h104);
    check("pt_valid",  ex_valid, 1'b1);

    // load-use: lw $8 then add reading $8 via rs
    drvLoad(5'd1, 5'd8, 32'h4);
    tick();
    check("lu_exmemrd", ex_MemRead, 1'b1);
    drvR(5'd8, 5'd3, 5'd4, 32'h11, 32'h22);
    #1 check("lu_stall", stall, 1'b1);
    tick();
    check("lu_bub_valid", ex_valid, 1'b0);
    check("lu_bub_regwr", ex_RegWrite, 1'b0);
    check("lu_bub_aluop", ex_ALUOp, 3'b000);
    check("lu_bub_rs",    ex_rs, 5'd8);
    check("lu_bub_rd1",   ex_rd1, 32'h11);
    check("lu_cnt",       stall_cnt, 2'd1);
    check("lu_stall2",    stall, 1'b0);
    tick();
    check("lu_rep_valid", ex_valid, 1'b1);
    check("lu_rep_regdst", ex_RegDst, 1'b1);
    check("lu_rep_rs",    ex_rs, 5'd8);
    check("lu_rep_cnt",   stall_cnt, 2'd1);

    // no false hazard on $0
    drvLoad(5'd2, 5'd0, 32'h0);
    tick();
    drvR(5'd0, 5'd5, 5'd6, 32'h1, 32'h2);
    #1 check("r0_stall", stall, 1'b0);

    // rt match only matters when rt is actually a source
    drvLoad(5'd2, 5'd9, 32'h0);
    tick();
    clearIn();
    valid_in = 1'b1; rs = 5'd1; rt = 5'd9; ALUSrc = 1'b1; MemWrite = 1'b0;
    #1 check("imm_rt_stall", stall, 1'b0);
    MemWrite = 1'b1;
    #1 check("sw_rt_stall", stall, 1'b1);
    MemWrite = 1'b0; ALUSrc = 1'b0;
    #1 check("rtype_rt_stall", stall, 1'b1);
    valid_in = 1'b0;
    #1 check("novalid_stall", stall, 1'b0);
    valid_in = 1'b1;
    tick();
    check("rt_cnt",   stall_cnt, 2'd2);
    check("rt_valid", ex_valid, 1'b0);
    clearIn();
    tick();

    // flush beats the hazard
    drvLoad(5'd1, 5'd8, 32'h0);
    tick();
    drvR(5'd8, 5'd3, 5'd4, 32'h33, 32'h44);
    flush = 1'b1;
    #1 check("fl_stall", stall, 1'b0);
    tick();
    check("fl_valid", ex_valid, 1'b0);
    check("fl_regwr", ex_RegWrite, 1'b0);
    check("fl_cnt",   stall_cnt, 2'd2);

    // load followed by a load that uses the first load's result as base
    drvLoad(5'd1, 5'd8, 32'h0);
    tick();
    drvLoad(5'd8, 5'd10, 32'h8);
    #1 check("ll_stall", stall, 1'b1);
    tick();
    check("ll_cnt",    stall_cnt, 2'd3);
    check("ll_memrd",  ex_MemRead, 1'b0);
    clearIn();
    tick();

    // saturation, then clear coincident with a stall
    stallEvent("sat", 1'b0, 2'd3);
    stallEvent("clr", 1'b1, 2'd0);

    // reset in the middle of a stall
    drvLoad(5'd1, 5'd8, 32'h0);
    tick();
    drvR(5'd8, 5'd3, 5'd4, 32'h55, 32'h66);
    #1 check("ms_stall", stall, 1'b1);
    tick();
    check("ms_cnt", stall_cnt, 2'd1);
    check("ms_rd1", ex_rd1, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    check("ar_rd1",   ex_rd1, 32'h0);
    check("ar_rs",    ex_rs, 5'd0);
    check("ar_cnt",   stall_cnt, 2'd0);
    check("ar_valid", ex_valid, 1'b0);
    check("ar_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drvR(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    #1 check("post_stall", stall, 1'b0);
    tick();
    check("post_valid",  ex_valid, 1'b1);
    check("post_rd1",    ex_rd1, 32'd5);
    check("post_regdst", ex_RegDst, 1'b1);
    check("post_cnt",    stall_cnt, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
